// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared definitions for the MMIO uart controller: I/O window base, register
// offsets, TX holding-register states and the window decode helper.
package mmio_uart_ctrl_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

  // Register offsets within the I/O window (addr[7:0])
  localparam logic [7:0] OFF_UART_CTRL = 8'h00;
  localparam logic [7:0] OFF_UART_RX   = 8'h04;
  localparam logic [7:0] OFF_UART_TX   = 8'h08;
  localparam logic [7:0] OFF_CYC_CNT   = 8'h10;
  localparam logic [7:0] OFF_INST_CNT  = 8'h14;
  localparam logic [7:0] OFF_CNT_RST   = 8'h18;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

  // Window hit: top nibble matches the base and the middle bits are all zero,
  // so only addr[7:0] selects a register.
  function automatic logic io_hit(input logic [31:0] addr, input logic [3:0] base_nib);
    return (addr[31:28] == base_nib) && (addr[27:8] == 20'h0_0000);
  endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// CPU load/store bus plus uart byte handshakes seen by the MMIO controller.
//   master : CPU/uart side (drives addr, wdata, we, re, uart_tx_ready, uart_rx_*)
//   slave  : controller side (drives rdata, uart_tx_*, uart_rx_ready)
interface mmio_uart_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  modport master (
    output addr, wdata, we, re, uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  addr, wdata, we, re, uart_tx_ready, uart_rx_data, uart_rx_valid,
    output rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head (dout = oldest entry).
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
// A push while full and a pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller between the CPU load/store path and the uart.
// Ports: clk, rst (sync, active-high), inst_retired (one pulse per retired
// instruction), bus (slave modport: CPU addr/wdata/we/re/rdata and the uart
// tx/rx byte handshakes). Read data is registered on the re cycle and held.
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter int          RX_FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE       = IO_BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_retired,
  mmio_uart_ctrl_if.slave  bus
);
  logic        hit_s;
  logic [7:0]  off_s;
  logic        store_s;
  logic        tx_wr_s;
  logic        cnt_clr_s;
  logic        rx_pop_s;
  logic [7:0]  rx_head_s;
  logic        rx_full_s;
  logic        rx_empty_s;
  logic [31:0] rd_mux_s;
  tx_state_e   tx_state_r;
  tx_state_e   tx_state_s;
  logic        tx_load_s;
  logic [7:0]  tx_data_r;
  logic [31:0] cyc_cnt_r;
  logic [31:0] inst_cnt_r;
  logic [31:0] rdata_r;
  logic        unused_wdata_s;

  assign hit_s          = io_hit(bus.addr, IO_BASE[31:28]);
  assign off_s          = bus.addr[7:0];
  assign store_s        = |bus.we;
  assign tx_wr_s        = hit_s & bus.we[0] & (off_s == OFF_UART_TX);
  assign cnt_clr_s      = hit_s & store_s & (off_s == OFF_CNT_RST);
  assign rx_pop_s       = hit_s & bus.re & (off_s == OFF_UART_RX);
  assign unused_wdata_s = ^bus.wdata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.uart_rx_valid),
    .din   (bus.uart_rx_data),
    .pop   (rx_pop_s),
    .dout  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s)
  );

  assign bus.uart_rx_ready = ~rx_full_s;
  assign bus.uart_tx_valid = (tx_state_r == TX_PEND);
  assign bus.uart_tx_data  = tx_data_r;
  assign bus.rdata         = rdata_r;

  // TX holding register next state: a new byte is only taken while idle.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_load_s  = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_wr_s) begin
          tx_state_s = TX_PEND;
          tx_load_s  = 1'b1;
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_PEND: begin
        if (bus.uart_tx_ready) tx_state_s = TX_IDLE;
        else                   tx_state_s = TX_PEND;
      end
      default: tx_state_s = TX_IDLE;
    endcase
  end

  // TX state and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
      tx_data_r  <= 8'h00;
    end else begin
      tx_state_r <= tx_state_s;
      if (tx_load_s) tx_data_r <= bus.wdata[7:0];
    end
  end

  // Free-running counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_s) begin
      cyc_cnt_r  <= 32'h0000_0000;
      inst_cnt_r <= 32'h0000_0000;
    end else begin
      cyc_cnt_r  <= cyc_cnt_r + 32'h0000_0001;
      if (inst_retired) inst_cnt_r <= inst_cnt_r + 32'h0000_0001;
    end
  end

  // Read mux over pre-edge state; non-hits and unmapped offsets read zero.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    if (hit_s) begin
      case (off_s)
        OFF_UART_CTRL: rd_mux_s = {30'h0, ~rx_empty_s, ~bus.uart_tx_valid};
        OFF_UART_RX:   rd_mux_s = rx_empty_s ? 32'h0000_0000 : {24'h00_0000, rx_head_s};
        OFF_CYC_CNT:   rd_mux_s = cyc_cnt_r;
        OFF_INST_CNT:  rd_mux_s = inst_cnt_r;
        default:       rd_mux_s = 32'h0000_0000;
      endcase
    end else begin
      rd_mux_s = 32'h0000_0000;
    end
  end

  // Registered load data, held between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'h0000_0000;
    end else if (bus.re) begin
      rdata_r <= rd_mux_s;
    end
  end
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;
  logic clk;
  logic rst;
  logic inst_retired;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  mmio_uart_ctrl_if bus();

  mmio_uart_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst_retired (inst_retired),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a);
    bus.addr = a;
    bus.re   = 1'b1;
    tick();
    bus.re   = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = w;
    tick();
    bus.we    = 4'h0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.uart_rx_data  = d;
    bus.uart_rx_valid = 1'b1;
    tick();
    bus.uart_rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] drain_exp [7];
    rst = 1'b1;
    inst_retired = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.we = 4'h0; bus.re = 1'b0;
    bus.uart_tx_ready = 1'b0; bus.uart_rx_data = 8'h00; bus.uart_rx_valid = 1'b0;
    tick(); tick();
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_tx_valid", {31'h0, bus.uart_tx_valid}, 32'h0);
    chk("reset_tx_data", {24'h0, bus.uart_tx_data}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rx_ready_after_reset", {31'h0, bus.uart_rx_ready}, 32'h1);

    // 1: status after reset, unmapped and non-hit reads
    load(32'h8000_0000); chk("status_idle", bus.rdata, 32'h1);
    tick(); tick();      chk("rdata_held", bus.rdata, 32'h1);
    load(32'h8000_0020); chk("unmapped_off", bus.rdata, 32'h0);
    load(32'h8000_0000);
    load(32'h9000_0000); chk("non_hit_nibble", bus.rdata, 32'h0);
    load(32'h8000_0000);
    load(32'h8000_0100); chk("non_hit_mid", bus.rdata, 32'h0);

    // 2: TX holding register with a stalled uart
    store(32'h8000_0008, 32'h0000_0041, 4'h1);
    for (int i = 0; i < 5; i++) begin
      chk("tx_valid_held", {31'h0, bus.uart_tx_valid}, 32'h1);
      chk("tx_data_held", {24'h0, bus.uart_tx_data}, 32'h41);
      tick();
    end
    load(32'h8000_0000); chk("status_tx_busy", bus.rdata, 32'h0);
    store(32'h8000_0008, 32'h0000_0042, 4'h1);
    chk("tx_second_dropped", {24'h0, bus.uart_tx_data}, 32'h41);
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    chk("tx_valid_cleared", {31'h0, bus.uart_tx_valid}, 32'h0);
    load(32'h8000_0000); chk("status_tx_free", bus.rdata, 32'h1);

    // 3: RX FIFO ordering and empty read
    push(8'h10); push(8'h20); push(8'h30);
    load(32'h8000_0000); chk("status_rx_nonempty", bus.rdata, 32'h3);
    load(32'h8000_0004); chk("rx_pop0", bus.rdata, 32'h10);
    load(32'h8000_0004); chk("rx_pop1", bus.rdata, 32'h20);
    load(32'h8000_0004); chk("rx_pop2", bus.rdata, 32'h30);
    load(32'h8000_0004); chk("rx_pop_empty", bus.rdata, 32'h0);
    load(32'h8000_0000); chk("status_rx_empty", bus.rdata, 32'h1);

    // 4: full FIFO back-pressure and concurrent push/pop when full
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    chk("rx_ready_full", {31'h0, bus.uart_rx_ready}, 32'h0);
    push(8'hEE);
    chk("rx_ready_still_full", {31'h0, bus.uart_rx_ready}, 32'h0);
    load(32'h8000_0004); chk("full_pop", bus.rdata, 32'h80);
    chk("rx_ready_after_pop", {31'h0, bus.uart_rx_ready}, 32'h1);
    push(8'h90);
    chk("rx_ready_refull", {31'h0, bus.uart_rx_ready}, 32'h0);
    bus.uart_rx_data = 8'h91; bus.uart_rx_valid = 1'b1;
    load(32'h8000_0004);
    bus.uart_rx_valid = 1'b0;
    chk("full_push_pop", bus.rdata, 32'h81);
    chk("rx_ready_count7", {31'h0, bus.uart_rx_ready}, 32'h1);
    drain_exp = '{8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h90};
    for (int i = 0; i < 7; i++) begin
      load(32'h8000_0004); chk($sformatf("drain%0d", i), bus.rdata, {24'h0, drain_exp[i]});
    end
    load(32'h8000_0004); chk("drain_empty", bus.rdata, 32'h0);

    // 5: counters
    store(32'h8000_0018, 32'h0, 4'hF);
    for (int i = 0; i < 100; i++) begin
      inst_retired = (i % 2 == 0);
      tick();
    end
    inst_retired = 1'b0;
    load(32'h8000_0010); chk("cyc_cnt_100", bus.rdata, 32'd100);
    load(32'h8000_0014); chk("inst_cnt_50", bus.rdata, 32'd50);
    store(32'h8000_0018, 32'h0, 4'h1);
    load(32'h8000_0010); chk("cyc_cleared", bus.rdata, 32'h0);
    load(32'h8000_0014); chk("inst_cleared", bus.rdata, 32'h0);
    load(32'h8000_0010); chk("cyc_resumed", bus.rdata, 32'd2);

    // 6: cycle counter wrap
    force dut.cyc_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_r;
    tick();
    load(32'h8000_0010); chk("cyc_wrap", bus.rdata, 32'h0);

    // 6: reset with TX pending and RX data buffered
    store(32'h8000_0008, 32'h0000_0055, 4'h1);
    push(8'hAA);
    chk("tx_pending_pre_rst", {31'h0, bus.uart_tx_valid}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rst_tx_valid", {31'h0, bus.uart_tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.uart_tx_data}, 32'h0);
    rst = 1'b0;
    tick();
    load(32'h8000_0000); chk("status_after_rst", bus.rdata, 32'h1);
    load(32'h8000_0004); chk("rx_after_rst", bus.rdata, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
